// File: rtl/ascon_pack.sv
// Shared types and round constants for the ASCON AEAD encryption sequencer.
package ascon_pack;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_WAIT_AD = 3'd2,
        ST_AD      = 3'd3,
        ST_WAIT_PT = 3'd4,
        ST_PT      = 3'd5,
        ST_FINAL   = 3'd6,
        ST_DONE    = 3'd7
    } type_fsm_state;

    localparam logic [3:0] ROUND_FIRST_P12 = 4'd0;
    localparam logic [3:0] ROUND_FIRST_P6  = 4'd6;
    localparam logic [3:0] ROUND_LAST      = 4'd11;

    // A block count of zero is processed as a single block.
    function automatic logic [3:0] clamp_blocks(input logic [3:0] n);
        return (n == 4'd0) ? 4'd1 : n;
    endfunction

endpackage

// File: rtl/round_counter.sv
// Permutation round index: synchronous load of the p12 or p6 start round, then counts up.
module round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic       load_i,
    input  logic       load_p6_i,
    output logic [3:0] count_o
);

    logic [3:0] count_q;

    // Load has priority over counting.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= ROUND_FIRST_P12;
        end else if (load_i) begin
            count_q <= load_p6_i ? ROUND_FIRST_P6 : ROUND_FIRST_P12;
        end else if (en_i) begin
            count_q <= count_q + 4'd1;
        end else begin
            count_q <= count_q;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ascon_fsm.sv
// ASCON AEAD encryption control FSM with registered datapath enables.
// Optional macro ASCON_FSM_ABORT_EN adds abort_i, which returns the FSM to IDLE without a done pulse.
module ascon_fsm
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
`ifdef ASCON_FSM_ABORT_EN
    input  logic       abort_i,
`endif
    input  logic [3:0] nb_blocks_i,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic [3:0] counter_o,
    output logic       data_sel_o,
    output logic       en_reg_state_o,
    output logic       en_xor_data_o,
    output logic       en_xor_key_o,
    output logic       en_xor_key_end_o,
    output logic       en_xor_lsb_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       busy_o,
    output logic       done_o
);

    type_fsm_state state_q;
    logic [3:0]    rem_q;
    logic [3:0]    cnt_s;
    logic          cnt_load_s, cnt_p6_s, cnt_en_s;
    logic          abort_s, last_s, first_s, mid_s;
    logic [3:0]    counter_q;
    logic          data_sel_q, en_reg_state_q, en_xor_data_q, en_xor_key_q;
    logic          en_xor_key_end_q, en_xor_lsb_q, en_cipher_q, en_tag_q, busy_q, done_q;

`ifdef ASCON_FSM_ABORT_EN
    assign abort_s = abort_i && (state_q != ST_IDLE);
`else
    assign abort_s = 1'b0;
`endif

    assign last_s  = (cnt_s == ROUND_LAST);
    assign first_s = (cnt_s == ROUND_FIRST_P12);
    assign mid_s   = (cnt_s == ROUND_FIRST_P6);

    round_counter u_round_counter (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .en_i      (cnt_en_s),
        .load_i    (cnt_load_s),
        .load_p6_i (cnt_p6_s),
        .count_o   (cnt_s)
    );

    // The counter is loaded on the edge that enters a permutation state and frozen in WAIT states.
    always_comb begin
        cnt_load_s = 1'b0;
        cnt_p6_s   = 1'b0;
        cnt_en_s   = 1'b0;
        if (abort_s) begin
            cnt_load_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE:                         cnt_load_s = start_i;
                ST_INIT, ST_AD, ST_PT, ST_FINAL: cnt_en_s   = !last_s;
                ST_WAIT_AD: begin
                    cnt_load_s = data_valid_i;
                    cnt_p6_s   = 1'b1;
                end
                ST_WAIT_PT: begin
                    cnt_load_s = data_valid_i;
                    cnt_p6_s   = (rem_q > 4'd1);
                end
                default:                         cnt_en_s   = 1'b0;
            endcase
        end
    end

    // Outputs are decoded from the current state, so they trail the state register by one edge.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q          <= ST_IDLE;
            rem_q            <= 4'd0;
            counter_q        <= 4'd0;
            data_sel_q       <= 1'b0;
            en_reg_state_q   <= 1'b0;
            en_xor_data_q    <= 1'b0;
            en_xor_key_q     <= 1'b0;
            en_xor_key_end_q <= 1'b0;
            en_xor_lsb_q     <= 1'b0;
            en_cipher_q      <= 1'b0;
            en_tag_q         <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else if (abort_s) begin
            state_q          <= ST_IDLE;
            rem_q            <= 4'd0;
            counter_q        <= 4'd0;
            data_sel_q       <= 1'b0;
            en_reg_state_q   <= 1'b0;
            en_xor_data_q    <= 1'b0;
            en_xor_key_q     <= 1'b0;
            en_xor_key_end_q <= 1'b0;
            en_xor_lsb_q     <= 1'b0;
            en_cipher_q      <= 1'b0;
            en_tag_q         <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            counter_q        <= cnt_s;
            data_sel_q       <= ((state_q == ST_INIT) && !first_s) || (state_q == ST_AD)
                                || (state_q == ST_PT) || (state_q == ST_FINAL);
            en_reg_state_q   <= (state_q == ST_INIT) || (state_q == ST_AD)
                                || (state_q == ST_PT) || (state_q == ST_FINAL);
            en_xor_data_q    <= (((state_q == ST_AD) || (state_q == ST_PT)) && mid_s)
                                || ((state_q == ST_FINAL) && first_s);
            en_xor_key_q     <= (state_q == ST_FINAL) && first_s;
            en_xor_key_end_q <= ((state_q == ST_INIT) || (state_q == ST_FINAL)) && last_s;
            en_xor_lsb_q     <= (state_q == ST_AD) && last_s;
            en_cipher_q      <= ((state_q == ST_PT) && mid_s) || ((state_q == ST_FINAL) && first_s);
            en_tag_q         <= (state_q == ST_FINAL) && last_s;
            busy_q           <= (state_q != ST_IDLE);
            done_q           <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_INIT;
                        rem_q   <= clamp_blocks(nb_blocks_i);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_INIT:    state_q <= last_s ? ST_WAIT_AD : ST_INIT;
                ST_WAIT_AD: state_q <= data_valid_i ? ST_AD : ST_WAIT_AD;
                ST_AD:      state_q <= last_s ? ST_WAIT_PT : ST_AD;
                ST_WAIT_PT: begin
                    if (data_valid_i) begin
                        state_q <= (rem_q > 4'd1) ? ST_PT : ST_FINAL;
                    end else begin
                        state_q <= ST_WAIT_PT;
                    end
                end
                ST_PT: begin
                    if (last_s) begin
                        state_q <= ST_WAIT_PT;
                        rem_q   <= rem_q - 4'd1;
                    end else begin
                        state_q <= ST_PT;
                    end
                end
                ST_FINAL:   state_q <= last_s ? ST_DONE : ST_FINAL;
                ST_DONE:    state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_ready_o     = (state_q == ST_WAIT_AD) || (state_q == ST_WAIT_PT);
    assign counter_o        = counter_q;
    assign data_sel_o       = data_sel_q;
    assign en_reg_state_o   = en_reg_state_q;
    assign en_xor_data_o    = en_xor_data_q;
    assign en_xor_key_o     = en_xor_key_q;
    assign en_xor_key_end_o = en_xor_key_end_q;
    assign en_xor_lsb_o     = en_xor_lsb_q;
    assign en_cipher_o      = en_cipher_q;
    assign en_tag_o         = en_tag_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

endmodule
